// File: rtl/nor_test_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// nor_test_sequencer_pkg
//
// Shared definitions for the NOR gate test sequencer and the gate sequencers
// that will follow it:
//   - seq_state_e : sequencer FSM states (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//   - NUM_VEC     : number of input vectors swept (all combinations of a,b)
//   - VEC_W/ERR_W : widths of the vector index and the mismatch counter
//   - nor_expected: reference value of a 2-input NOR for a given {a,b}
// ---------------------------------------------------------------------------
package nor_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;
    // Counter must hold 0..NUM_VEC, so one bit more than the vector index.
    localparam int ERR_W   = 3;

    function automatic logic nor_expected(input logic [VEC_W-1:0] v);
        return ~(v[1] | v[0]);
    endfunction

endpackage

// File: rtl/nor_test_sequencer_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
//
// Parameterised settle counter. `load` restarts a settle interval, `en`
// advances it by one cycle, and `expire` is high during the last cycle of
// an interval of LIMIT cycles (i.e. on the LIMIT-th enabled cycle after a
// load). COUNT_DOWN selects whether the internal count runs LIMIT-1 -> 0 or
// 0 -> LIMIT-1; the observable behaviour of `expire` is the same.
//
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   load   in  start a new interval (priority over en)
//   en     in  advance the interval by one cycle
//   expire out last cycle of the current interval
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int LIMIT      = 1,
    parameter bit COUNT_DOWN = 1'b0,
    parameter int CNT_W      = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] scnt_q;
    logic [CNT_W-1:0] scnt_d;

    generate
        if (COUNT_DOWN) begin : g_down
            always_comb begin
                scnt_d = scnt_q;
                if (load) begin
                    scnt_d = LAST;
                end else if (en && (scnt_q != '0)) begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            assign expire = (scnt_q == '0);
        end else begin : g_up
            always_comb begin
                scnt_d = scnt_q;
                if (load) begin
                    scnt_d = '0;
                end else if (en && (scnt_q != LAST)) begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            assign expire = (scnt_q == LAST);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: rtl/nor_test_sequencer.sv
// ---------------------------------------------------------------------------
// nor_test_sequencer
//
// Self-checking stimulus controller for a 2-input NOR gate. A `start` in
// IDLE sweeps {a,b} through 00,01,10,11; each vector is held for
// SETTLE_CYCLES cycles (SETTLE) and then the gate output is compared with
// the expected NOR value for one cycle (SAMPLE). After the last vector a
// one-cycle DONE reports the result. Results persist until the next
// accepted start or reset.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (IDLE only; abort in the same cycle wins)
//   abort      in   cancel a sweep, any state
//   dut_a      out  gate input a (registered)
//   dut_b      out  gate input b (registered)
//   dut_y      in   gate output
//   busy       out  high in SETTLE and SAMPLE
//   done       out  one-cycle pulse on sweep completion
//   pass       out  last completed sweep had zero mismatches
//   err_count  out  mismatches in the last/current sweep (0..4)
//   fail_vec   out  {a,b} of the first mismatch
//   fail_valid out  fail_vec holds a captured mismatch
// ---------------------------------------------------------------------------
module nor_test_sequencer
    import nor_test_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_valid
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    seq_state_e       state_q,      state_d;
    logic [VEC_W-1:0] vec_q,        vec_d;
    logic [VEC_W-1:0] dut_ab_q,     dut_ab_d;
    logic [ERR_W-1:0] err_count_q,  err_count_d;
    logic [VEC_W-1:0] fail_vec_q,   fail_vec_d;
    logic             fail_valid_q, fail_valid_d;
    logic             pass_q,       pass_d;

    logic timer_load;
    logic timer_en;
    logic timer_expire;

    settle_timer #(
        .LIMIT      (SETTLE_CYCLES),
        .COUNT_DOWN (1'b0)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_count_d  = err_count_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    vec_d        = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    timer_load   = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                // An aborted sample is discarded, mismatch or not.
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (dut_y != nor_expected(vec_q)) begin
                        err_count_d = err_count_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_vec_d   = vec_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d      = vec_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                pass_d  = abort ? 1'b0 : (err_count_q == '0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Gate inputs are registered: they follow the vector of the state
        // being entered, and idle at 00 outside the sweep.
        if ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) begin
            dut_ab_d = vec_d;
        end else begin
            dut_ab_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            dut_ab_q     <= '0;
            err_count_q  <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            dut_ab_q     <= dut_ab_d;
            err_count_q  <= err_count_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_a      = dut_ab_q[1];
    assign dut_b      = dut_ab_q[0];
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    // An abort arriving in DONE suppresses the completion pulse.
    assign done       = (state_q == ST_DONE) && !abort;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_nor_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nor_test_sequencer
//
// Two sequencer instances share the clock: index 0 uses SETTLE_CYCLES=1,
// index 1 uses SETTLE_CYCLES=3. Each drives its own behavioural gate whose
// truth table (tt[{a,b}]) is set per sweep: correct NOR, OR, stuck-at-1 or
// random. Expected waveforms and results come from the timing formulas and
// a per-vector mismatch count over the truth table.
// ---------------------------------------------------------------------------
module tb_nor_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_s      [2];
    logic       start_s    [2];
    logic       abort_s    [2];
    logic       a_s        [2];
    logic       b_s        [2];
    logic       y_s        [2];
    logic       busy_s     [2];
    logic       done_s     [2];
    logic       pass_s     [2];
    logic [2:0] err_s      [2];
    logic [1:0] fvec_s     [2];
    logic       fvalid_s   [2];
    logic [3:0] tt_s       [2];

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_STUCK = 4'b1111;

    always #5 clk = ~clk;

    assign y_s[0] = tt_s[0][{a_s[0], b_s[0]}];
    assign y_s[1] = tt_s[1][{a_s[1], b_s[1]}];

    nor_test_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .dut_a(a_s[0]), .dut_b(b_s[0]), .dut_y(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_count(err_s[0]), .fail_vec(fvec_s[0]), .fail_valid(fvalid_s[0])
    );

    nor_test_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .dut_a(a_s[1]), .dut_b(b_s[1]), .dut_y(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_count(err_s[1]), .fail_vec(fvec_s[1]), .fail_valid(fvalid_s[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // {busy, done, dut_a, dut_b}
    function automatic logic [3:0] ctl_of(input int d);
        return {busy_s[d], done_s[d], a_s[d], b_s[d]};
    endfunction

    // A correct NOR is 1 only for input 00.
    function automatic logic nor_ref(input int k);
        return (k == 0);
    endfunction

    // Mismatch count and first failing vector over vectors 0..nvec-1.
    task automatic model(input logic [3:0] tt, input int nvec,
                         output int err, output int first);
        err   = 0;
        first = -1;
        for (int k = 0; k < nvec; k++) begin
            if (tt[k] != nor_ref(k)) begin
                err++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic check_results(input int d, input string tag, input logic exp_pass,
                                 input int exp_err, input int exp_first);
        check({tag, "_pass"}, pass_s[d], exp_pass);
        check({tag, "_err"}, err_s[d], exp_err);
        check({tag, "_fvalid"}, fvalid_s[d], exp_first >= 0);
        if (exp_first >= 0) check({tag, "_fvec"}, fvec_s[d], exp_first);
    endtask

    // Full sweep. Cycle 0 is the cycle in which start is high.
    task automatic sweep(input int d, input logic [3:0] tt, input bit extra_starts);
        int s, dn, err, first;
        logic [3:0] exp;
        s  = settle_of(d);
        dn = 4 * (s + 1) + 1;
        model(tt, 4, err, first);
        @(negedge clk);
        tt_s[d]    = tt;
        start_s[d] = 1'b1;
        for (int c = 1; c <= dn + 1; c++) begin
            @(negedge clk);
            start_s[d] = 1'b0;
            if (c < dn) exp = {1'b1, 1'b0, 2'((c - 1) / (s + 1))};
            else if (c == dn) exp = 4'b0100;
            else exp = 4'b0000;
            check($sformatf("sweep%0d_c%0d", d, c), ctl_of(d), exp);
            if (extra_starts && (c == 5 || c == 17)) start_s[d] = 1'b1;
        end
        check_results(d, $sformatf("sweep%0d", d), err == 0, err, first);
        $display("sweep dut%0d tt=%b err=%0d first=%0d pass=%0d", d, tt, err_s[d], first, pass_s[d]);
    endtask

    // Abort at cycle 4 (SAMPLE of vector 1 with SETTLE_CYCLES=1).
    task automatic abort_test(input logic [3:0] tt);
        int err, first;
        logic [3:0] exp;
        model(tt, 1, err, first);   // only vector 0 gets sampled
        @(negedge clk);
        tt_s[0]    = tt;
        start_s[0] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            abort_s[0] = 1'b0;
            exp = (c <= 4) ? {2'b10, 2'((c - 1) / 2)} : 4'b0000;
            check($sformatf("abort_c%0d", c), ctl_of(0), exp);
            if (c == 4) abort_s[0] = 1'b1;
        end
        check_results(0, "abort", 1'b0, err, first);
        $display("abort dut0 tt=%b err=%0d", tt, err_s[0]);
    endtask

    task automatic start_abort_test();
        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            abort_s[0] = 1'b0;
            check($sformatf("stab_c%0d", c), ctl_of(0), 4'b0000);
        end
        $display("start+abort dut0 busy=%0d", busy_s[0]);
    endtask

    task automatic reset_test();
        @(negedge clk);
        tt_s[0]    = TT_OR;
        start_s[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            if (c == 5) begin
                check("rst_pre_err", err_s[0], 3'd2);
                rst_s[0] = 1'b1;
            end
        end
        @(negedge clk);
        rst_s[0] = 1'b0;
        check("rst_outs", {ctl_of(0), pass_s[0], err_s[0], fvec_s[0], fvalid_s[0]}, 11'd0);
        $display("reset mid-sweep dut0 outs=%b", {ctl_of(0), pass_s[0], err_s[0], fvec_s[0], fvalid_s[0]});
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d]   = 1'b1;
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            tt_s[d]    = TT_NOR;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d", d),
                  {ctl_of(d), pass_s[d], err_s[d], fvec_s[d], fvalid_s[d]}, 11'd0);
            rst_s[d] = 1'b0;
        end

        sweep(0, TT_NOR, 1'b0);
        sweep(0, TT_OR, 1'b0);
        sweep(0, TT_STUCK, 1'b0);
        sweep(0, TT_NOR, 1'b0);
        sweep(1, TT_NOR, 1'b1);
        sweep(1, TT_OR, 1'b0);
        abort_test(TT_NOR);
        abort_test(4'b0111);        // miss on vector 1 falls on the aborted sample
        abort_test(4'($urandom_range(0, 15)));
        start_abort_test();
        reset_test();
        sweep(0, TT_NOR, 1'b0);

        for (int i = 0; i < 12; i++) begin
            sweep(i % 2, 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
